// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage.
//   PWM_WIDTH_DEF : default duty / period-counter width
//   PWM_DEAD_DEF  : default dead-band length in cycles
//   db_state_t    : dead-band FSM states (used when PWM_DEADTIME_EN is defined)
package pwm_pkg;

    localparam int unsigned PWM_WIDTH_DEF = 5;
    localparam int unsigned PWM_DEAD_DEF  = 2;

    typedef enum logic [1:0] {
        LO  = 2'd0,
        DLH = 2'd1,
        HI  = 2'd2,
        DHL = 2'd3
    } db_state_t;

endpackage

// File: rtl/pwm_deadband.sv
// Dead-band generator for complementary half-bridge drive.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   raw      in  raw PWM level for the cycle about to be displayed
//   pwm_out  out high-side drive, registered
//   pwm_n    out low-side drive, registered
// The two outputs are never high together; every transition passes
// through a both-off state lasting at least DEAD cycles.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int unsigned DEAD = PWM_DEAD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pwm_out,
    output logic pwm_n
);

    localparam int unsigned HOLD_W = 3;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DEAD - 1);

    db_state_t         r_state;
    db_state_t         w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;

    // State register; outputs are decoded from the next state so they
    // stay aligned with the counter value shown alongside them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DHL;
            r_hold  <= '0;
            pwm_out <= 1'b0;
            pwm_n   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            pwm_out <= (w_state_nxt == HI);
            pwm_n   <= (w_state_nxt == LO);
        end
    end

    // Next-state logic; a reversal of raw during a gap restarts the count.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            LO: begin
                if (raw) begin
                    w_state_nxt = DLH;
                    w_hold_nxt  = '0;
                end
            end
            DLH: begin
                if (!raw) begin
                    w_state_nxt = DHL;
                    w_hold_nxt  = '0;
                end else if (r_hold == HOLD_LAST) begin
                    w_state_nxt = HI;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            HI: begin
                if (!raw) begin
                    w_state_nxt = DHL;
                    w_hold_nxt  = '0;
                end
            end
            DHL: begin
                if (raw) begin
                    w_state_nxt = DLH;
                    w_hold_nxt  = '0;
                end else if (r_hold == HOLD_LAST) begin
                    w_state_nxt = LO;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = DHL;
                w_hold_nxt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/pwm_mod.sv
// PWM output stage with double-buffered duty word.
// Ports:
//   clk           in  system clock
//   rst           in  synchronous active-high reset
//   duty_in       in  duty word from the upstream accumulator
//   ld            in  strobe capturing duty_in into the shadow register
//   cnt           out current period-counter value
//   period_start  out high for the cycle where cnt == 0
//   upd_pend      out shadow written but not yet applied
//   pwm_out       out PWM output, high side
//   pwm_n         out complementary output
// Build option: PWM_DEADTIME_EN adds a dead-band FSM between the compare
// and the outputs; otherwise pwm_n is the plain inverse of pwm_out.
module pwm_mod
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH_DEF,
    parameter int unsigned DEAD  = PWM_DEAD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             ld,
    output logic [WIDTH-1:0] cnt,
    output logic             period_start,
    output logic             upd_pend,
    output logic             pwm_out,
    output logic             pwm_n
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    if (DEAD < 1 || DEAD > 7) begin : g_dead_range
        $error("pwm_mod: DEAD must be within 1..7");
    end

    // Internal phase resets to the last count so the first edge after
    // release is a period boundary and cnt shows 0 with period_start.
    logic [WIDTH-1:0] r_phase;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_duty_act;

    logic             w_wrap;
    logic [WIDTH-1:0] w_phase_nxt;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic [WIDTH-1:0] w_duty_nxt;
    logic             w_pend_nxt;
    logic             w_raw_nxt;

    // Next-state values; a load on the boundary cycle bypasses the shadow.
    always_comb begin
        w_wrap       = (r_phase == CNT_MAX);
        w_phase_nxt  = r_phase + WIDTH'(1);
        w_shadow_nxt = ld ? duty_in : r_shadow;
        w_duty_nxt   = w_wrap ? w_shadow_nxt : r_duty_act;
        w_pend_nxt   = w_wrap ? 1'b0 : (ld | upd_pend);
        w_raw_nxt    = (w_phase_nxt < w_duty_nxt);
    end

    // Counter, duty buffers and the aligned status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= CNT_MAX;
            r_shadow     <= '0;
            r_duty_act   <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
            upd_pend     <= 1'b0;
        end else begin
            r_phase      <= w_phase_nxt;
            r_shadow     <= w_shadow_nxt;
            r_duty_act   <= w_duty_nxt;
            cnt          <= w_phase_nxt;
            period_start <= (w_phase_nxt == '0);
            upd_pend     <= w_pend_nxt;
        end
    end

`ifdef PWM_DEADTIME_EN
    pwm_deadband #(
        .DEAD (DEAD)
    ) u_deadband (
        .clk     (clk),
        .rst     (rst),
        .raw     (w_raw_nxt),
        .pwm_out (pwm_out),
        .pwm_n   (pwm_n)
    );
`else
    // Plain complementary drive; both low while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= 1'b0;
            pwm_n   <= 1'b0;
        end else begin
            pwm_out <= w_raw_nxt;
            pwm_n   <= ~w_raw_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_mod.sv
// Directed testbench for pwm_mod (WIDTH = 5, DEAD = 2).
module tb_pwm_mod;

    logic       clk;
    logic       rst;
    logic [4:0] duty_in;
    logic       ld;
    logic [4:0] cnt;
    logic       period_start;
    logic       upd_pend;
    logic       pwm_out;
    logic       pwm_n;

    int n_checks;
    int n_fail;

    pwm_mod #(
        .WIDTH (5),
        .DEAD  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .duty_in      (duty_in),
        .ld           (ld),
        .cnt          (cnt),
        .period_start (period_start),
        .upd_pend     (upd_pend),
        .pwm_out      (pwm_out),
        .pwm_n        (pwm_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Advance until cnt shows v; an expired bound is counted as a failure.
    task automatic go_to_cnt(input int v);
        for (int i = 0; i < 40; i++) begin
            if (int'(cnt) == v) return;
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL go_to_cnt: cnt never reached %0d (now %0d)", v, cnt);
    endtask

    task automatic pulse_ld(input logic [4:0] v);
        ld      = 1'b1;
        duty_in = v;
        tick();
        ld      = 1'b0;
    endtask

    // Record one full period starting at cnt == 0, bit index = cnt.
    task automatic capture_period(output logic [31:0] hi, output logic [31:0] lo_n,
                                  output logic [31:0] pend, output logic [31:0] ps);
        hi = '0; lo_n = '0; pend = '0; ps = '0;
        go_to_cnt(0);
        for (int i = 0; i < 32; i++) begin
            hi[cnt]   = pwm_out;
            lo_n[cnt] = pwm_n;
            pend[cnt] = upd_pend;
            ps[cnt]   = period_start;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ld = 1'b0; duty_in = '0;
        repeat (3) tick();
        n_checks++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps: got %b want 0", period_start); end
        n_checks++; if (upd_pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b want 0", upd_pend); end
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        n_checks++; if (pwm_n !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_n: got %b want 0", pwm_n); end
        rst = 1'b0;
        tick();
        n_checks++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL release_cnt: got %0d want 0", cnt); end
        n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL release_ps: got %b want 1", period_start); end
`ifndef PWM_DEADTIME_EN
        n_checks++; if (pwm_n !== 1'b1) begin n_fail++; $display("FAIL release_pwm_n: got %b want 1", pwm_n); end
`endif
        tick();
        n_checks++; if (cnt !== 5'd1) begin n_fail++; $display("FAIL release_cnt1: got %0d want 1", cnt); end
    endtask

    task automatic test_idle();
        int ps_cnt;
        int hi_cnt;
        int n_low;
        ps_cnt = 0; hi_cnt = 0; n_low = 0;
        for (int i = 0; i < 64; i++) begin
            if (period_start) ps_cnt++;
            if (pwm_out) hi_cnt++;
            if (!pwm_n) n_low++;
            if (period_start && cnt != 5'd0) ps_cnt += 100;
            tick();
        end
        n_checks++; if (ps_cnt != 2) begin n_fail++; $display("FAIL idle_ps: got %0d pulses want 2", ps_cnt); end
        n_checks++; if (hi_cnt != 0) begin n_fail++; $display("FAIL idle_pwm: got %0d high cycles want 0", hi_cnt); end
`ifndef PWM_DEADTIME_EN
        n_checks++; if (n_low != 0) begin n_fail++; $display("FAIL idle_pwm_n: got %0d low cycles want 0", n_low); end
`endif
    endtask

    task automatic test_load8();
        logic [31:0] hi, lo_n, pend, ps;
        int pend_hi;
        go_to_cnt(13);
        pulse_ld(5'd8);
        n_checks++; if (upd_pend !== 1'b1 || cnt !== 5'd14) begin
            n_fail++; $display("FAIL load8_pend14: got pend=%b cnt=%0d want 1 at 14", upd_pend, cnt); end
        pend_hi = 0;
        for (int i = 0; i < 18; i++) begin
            if (upd_pend) pend_hi++;
            tick();
        end
        n_checks++; if (pend_hi != 18) begin n_fail++; $display("FAIL load8_pend_span: got %0d want 18", pend_hi); end
        n_checks++; if (upd_pend !== 1'b0 || cnt !== 5'd0) begin
            n_fail++; $display("FAIL load8_pend0: got pend=%b cnt=%0d want 0 at 0", upd_pend, cnt); end
        capture_period(hi, lo_n, pend, ps);
        n_checks++; if (hi !== 32'h0000_00FF) begin n_fail++; $display("FAIL load8_mask: got %h want 000000ff", hi); end
        n_checks++; if (ps !== 32'h0000_0001) begin n_fail++; $display("FAIL load8_ps: got %h want 00000001", ps); end
    endtask

    task automatic test_bypass();
        logic [31:0] hi, lo_n, pend, ps;
        go_to_cnt(31);
        pulse_ld(5'd20);
        n_checks++; if (upd_pend !== 1'b0) begin n_fail++; $display("FAIL bypass_pend: got %b want 0", upd_pend); end
        capture_period(hi, lo_n, pend, ps);
        n_checks++; if (hi !== 32'h000F_FFFF) begin n_fail++; $display("FAIL bypass_mask: got %h want 000fffff", hi); end
        n_checks++; if (pend !== 32'h0) begin n_fail++; $display("FAIL bypass_pend_mask: got %h want 00000000", pend); end
    endtask

    task automatic test_last_wins();
        logic [31:0] hi, lo_n, pend, ps;
        go_to_cnt(5);
        pulse_ld(5'd31);
        capture_period(hi, lo_n, pend, ps);
        n_checks++; if (hi !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL duty31_mask: got %h want 7fffffff", hi); end
        go_to_cnt(3);
        pulse_ld(5'd5);
        go_to_cnt(20);
        pulse_ld(5'd9);
        capture_period(hi, lo_n, pend, ps);
        n_checks++; if (hi !== 32'h0000_01FF) begin n_fail++; $display("FAIL last_wins_mask: got %h want 000001ff", hi); end
`ifndef PWM_DEADTIME_EN
        n_checks++; if (lo_n !== 32'hFFFF_FE00) begin n_fail++; $display("FAIL last_wins_n: got %h want fffffe00", lo_n); end
`endif
    endtask

`ifdef PWM_DEADTIME_EN
    task automatic test_deadband();
        logic [31:0] hi, lo_n, pend, ps;
        go_to_cnt(4);
        pulse_ld(5'd10);
        capture_period(hi, lo_n, pend, ps);
        n_checks++; if (hi !== 32'h0000_03FC) begin n_fail++; $display("FAIL db10_hi: got %h want 000003fc", hi); end
        n_checks++; if (lo_n !== 32'hFFFF_F000) begin n_fail++; $display("FAIL db10_n: got %h want fffff000", lo_n); end
        go_to_cnt(4);
        pulse_ld(5'd2);
        capture_period(hi, lo_n, pend, ps);
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL db2_hi: got %h want 00000000", hi); end
        n_checks++; if (lo_n !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL db2_n: got %h want fffffff0", lo_n); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] hi, lo_n, pend, ps;
        go_to_cnt(5);
        pulse_ld(5'd12);
        go_to_cnt(17);
        n_checks++; if (upd_pend !== 1'b1) begin n_fail++; $display("FAIL rmid_pend_before: got %b want 1", upd_pend); end
        rst = 1'b1;
        tick();
        n_checks++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 0", cnt); end
        n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL rmid_ps: got %b want 0", period_start); end
        n_checks++; if (upd_pend !== 1'b0) begin n_fail++; $display("FAIL rmid_pend: got %b want 0", upd_pend); end
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL rmid_pwm: got %b want 0", pwm_out); end
        n_checks++; if (pwm_n !== 1'b0) begin n_fail++; $display("FAIL rmid_pwm_n: got %b want 0", pwm_n); end
        rst = 1'b0;
        tick();
        capture_period(hi, lo_n, pend, ps);
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rmid_mask: got %h want 00000000", hi); end
        n_checks++; if (pend !== 32'h0) begin n_fail++; $display("FAIL rmid_pend_mask: got %h want 00000000", pend); end
`ifndef PWM_DEADTIME_EN
        n_checks++; if (lo_n !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rmid_n_mask: got %h want ffffffff", lo_n); end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ld       = 1'b0;
        duty_in  = '0;
        tick();
        test_reset();
        test_idle();
        test_load8();
        test_bypass();
        test_last_wins();
`ifdef PWM_DEADTIME_EN
        test_deadband();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
